// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoded control and forwarded operands for EXE,
// detects load-use hazards, inserts bubbles, and honours flush/hold from neighbours.
module id_ex_pipe #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid_i,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [4:0]         id_rs1_addr_i,
  input  logic [4:0]         id_rs2_addr_i,
  input  logic               id_rs1_re_i,
  input  logic               id_rs2_re_i,
  input  logic [XLEN-1:0]    id_op1_data_i,
  input  logic [XLEN-1:0]    id_op2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic [4:0]         id_rd_addr_i,
  input  logic               id_rd_we_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  input  logic               id_mem_re_i,
  input  logic               id_mem_we_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [XLEN-1:0]    ex_op1_o,
  output logic [XLEN-1:0]    ex_op2_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [4:0]         ex_rd_addr_o,
  output logic               ex_rd_we_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic               ex_mem_re_o,
  output logic               ex_mem_we_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rd;
    logic               rd_we;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_re;
    logic               mem_we;
  } ex_ctrl_t;

  ex_ctrl_t         ex_q;
  ex_ctrl_t         id_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rs1_hit, rs2_hit, luh;

  assign id_d = '{valid: id_valid_i, pc: id_pc_i, op1: id_op1_data_i, op2: id_op2_data_i,
                  imm: id_imm_i, rd: id_rd_addr_i, rd_we: id_rd_we_i, alu_op: id_alu_op_i,
                  mem_re: id_mem_re_i, mem_we: id_mem_we_i};

  // Load data only exists after MEM, so a consumer right behind a load must wait a cycle.
  assign rs1_hit = id_rs1_re_i && (id_rs1_addr_i == ex_q.rd);
  assign rs2_hit = id_rs2_re_i && (id_rs2_addr_i == ex_q.rd);
  assign luh     = id_valid_i && ex_q.valid && ex_q.mem_re && (ex_q.rd != 5'd0) &&
                   (rs1_hit || rs2_hit);
  assign stall_o = hold_i || (luh && !flush_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      // Flush wins over hold: the instruction in ID must die regardless.
      ex_q <= '0;
    end else if (hold_i) begin
      ex_q <= ex_q;
    end else if (luh) begin
      ex_q  <= '0;
      cnt_q <= cnt_q + 1'b1;
    end else begin
      ex_q <= id_d;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = ex_q.pc;
  assign ex_op1_o     = ex_q.op1;
  assign ex_op2_o     = ex_q.op2;
  assign ex_imm_o     = ex_q.imm;
  assign ex_rd_addr_o = ex_q.rd;
  assign ex_rd_we_o   = ex_q.rd_we;
  assign ex_alu_op_o  = ex_q.alu_op;
  assign ex_mem_re_o  = ex_q.mem_re;
  assign ex_mem_we_o  = ex_q.mem_we;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe (CNT_W=4): directed vector table, hold and wrap sequences,
// then random traffic against a rule-level reference model.
module tb_id_ex_pipe;
  localparam int XLEN = 32, ALUOP_W = 5, CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid_i, id_rs1_re_i, id_rs2_re_i, id_rd_we_i, id_mem_re_i, id_mem_we_i;
  logic flush_i, hold_i, stall_o;
  logic [XLEN-1:0] id_pc_i, id_op1_data_i, id_op2_data_i, id_imm_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [ALUOP_W-1:0] id_alu_op_i;
  logic ex_valid_o, ex_rd_we_o, ex_mem_re_o, ex_mem_we_o;
  logic [XLEN-1:0] ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o;
  logic [4:0] ex_rd_addr_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  id_ex_pipe #(.XLEN(XLEN), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .id_op1_data_i(id_op1_data_i), .id_op2_data_i(id_op2_data_i), .id_imm_i(id_imm_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i), .id_alu_op_i(id_alu_op_i),
    .id_mem_re_i(id_mem_re_i), .id_mem_we_i(id_mem_we_i), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_op1_o(ex_op1_o),
    .ex_op2_o(ex_op2_o), .ex_imm_o(ex_imm_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_we_o(ex_rd_we_o), .ex_alu_op_o(ex_alu_op_o), .ex_mem_re_o(ex_mem_re_o),
    .ex_mem_we_o(ex_mem_we_o), .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct {
    bit rst_n, valid, re1, re2, we, mre, mwe, flush, hold;
    logic [4:0] rs1, rs2, rd, aluop;
    logic [31:0] pc, op1, op2, imm;
  } in_t;

  typedef struct {
    in_t in;
    bit e_stall, e_valid;
    logic [4:0] e_rd;
    logic [31:0] e_op1;
    int e_cnt;
  } vec_t;

  // Model of what EXE should be holding
  typedef struct {
    bit valid, we, mre, mwe;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0] rd, aluop;
  } ex_m_t;

  ex_m_t m;
  int    mcnt = 0;
  bit    mcheck = 0;
  int    n_pass = 0, n_total = 0;
  vec_t  tbl[$];

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic in_t mk(bit rst, bit valid, logic [4:0] rs1, bit re1, logic [4:0] rs2,
                             bit re2, logic [31:0] op1, logic [4:0] rd, bit we, bit mre,
                             bit mwe, bit flush, bit hold);
    in_t v;
    v.rst_n = rst; v.valid = valid; v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2;
    v.op1 = op1; v.op2 = op1 + 1; v.pc = op1 * 4; v.imm = op1 ^ 32'hff;
    v.rd = rd; v.we = we; v.aluop = rd; v.mre = mre; v.mwe = mwe;
    v.flush = flush; v.hold = hold;
    return v;
  endfunction

  function automatic in_t lw5(logic [31:0] op1);
    return mk(1, 1, 5'd1, 1, 5'd2, 0, op1, 5'd5, 1, 1, 0, 0, 0);
  endfunction

  function automatic logic [159:0] m_bundle();
    return {m.valid, m.pc, m.op1, m.op2, m.imm, m.rd, m.we, m.aluop, m.mre, m.mwe};
  endfunction

  function automatic logic [159:0] dut_bundle();
    return {ex_valid_o, ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o, ex_rd_addr_o, ex_rd_we_o,
            ex_alu_op_o, ex_mem_re_o, ex_mem_we_o};
  endfunction

  // Apply one cycle of ID inputs; stall is sampled mid-cycle, registers after the edge.
  task automatic cycle(input in_t v, output bit st);
    bit haz, mstall;
    ex_m_t nxt;
    rst_n = v.rst_n; id_valid_i = v.valid; id_pc_i = v.pc;
    id_rs1_addr_i = v.rs1; id_rs2_addr_i = v.rs2; id_rs1_re_i = v.re1; id_rs2_re_i = v.re2;
    id_op1_data_i = v.op1; id_op2_data_i = v.op2; id_imm_i = v.imm;
    id_rd_addr_i = v.rd; id_rd_we_i = v.we; id_alu_op_i = v.aluop;
    id_mem_re_i = v.mre; id_mem_we_i = v.mwe; flush_i = v.flush; hold_i = v.hold;
    #1;
    st = stall_o;
    haz = v.valid && m.valid && m.mre && (m.rd != 0) &&
          ((v.re1 && v.rs1 == m.rd) || (v.re2 && v.rs2 == m.rd));
    mstall = v.hold || (haz && !v.flush);
    if (mcheck) check("stall", {159'b0, st}, {159'b0, mstall});
    nxt = '{default: '0};
    if (!v.rst_n) begin
      m = nxt; mcnt = 0;
    end else if (v.flush) begin
      m = nxt;
    end else if (v.hold) begin
      // EXE keeps its contents
    end else if (haz) begin
      m = nxt; mcnt = (mcnt + 1) % (1 << CNT_W);
    end else begin
      m.valid = v.valid; m.pc = v.pc; m.op1 = v.op1; m.op2 = v.op2; m.imm = v.imm;
      m.rd = v.rd; m.we = v.we; m.aluop = v.aluop; m.mre = v.mre; m.mwe = v.mwe;
    end
    @(posedge clk);
    #1;
    if (mcheck) begin
      check("ex_bundle", dut_bundle(), m_bundle());
      check("bubble_cnt", {156'b0, bubble_cnt_o}, mcnt);
    end
  endtask

  task automatic chk_ex(string tag, bit valid, logic [4:0] rd, logic [31:0] op1, int cnt);
    check({tag, ".valid"}, {159'b0, ex_valid_o}, {159'b0, valid});
    check({tag, ".rd"}, {155'b0, ex_rd_addr_o}, {155'b0, rd});
    check({tag, ".op1"}, {128'b0, ex_op1_o}, {128'b0, op1});
    check({tag, ".cnt"}, {156'b0, bubble_cnt_o}, cnt);
  endtask

  initial begin
    bit st;
    in_t v;
    rst_n = 0; id_valid_i = 0; id_pc_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; id_op1_data_i = 0; id_op2_data_i = 0; id_imm_i = 0;
    id_rd_addr_i = 0; id_rd_we_i = 0; id_alu_op_i = 0; id_mem_re_i = 0; id_mem_we_i = 0;
    flush_i = 0; hold_i = 0;
    m = '{default: '0};
    @(posedge clk); #1;

    //            rst v  rs1 re1 rs2 re2 op1 rd we mre mwe fl ho   stall valid rd op1 cnt
    tbl.push_back('{mk(0,1, 1,1, 2,1,  5, 3,1,0,0,0,0), 0, 0, 0,   0, 0});
    tbl.push_back('{mk(0,1, 1,1, 2,1,  5, 3,1,0,0,0,0), 0, 0, 0,   0, 0});
    tbl.push_back('{mk(1,1, 1,1, 2,1,  5, 3,1,0,0,0,0), 0, 1, 3,   5, 0});
    tbl.push_back('{lw5(100),                           0, 1, 5, 100, 0});
    tbl.push_back('{mk(1,1, 5,1, 2,1,  9, 6,1,0,0,0,0), 1, 0, 0,   0, 1});
    tbl.push_back('{mk(1,1, 5,1, 2,1,  9, 6,1,0,0,0,0), 0, 1, 6,   9, 1});
    tbl.push_back('{mk(1,1, 1,0, 2,0, 10, 0,1,1,0,0,0), 0, 1, 0,  10, 1});
    tbl.push_back('{mk(1,1, 0,1, 0,1, 14, 7,1,0,0,0,0), 0, 1, 7,  14, 1});
    tbl.push_back('{lw5(11),                            0, 1, 5,  11, 1});
    tbl.push_back('{mk(1,1, 2,1, 5,0, 12, 8,1,0,0,0,0), 0, 1, 8,  12, 1});
    tbl.push_back('{lw5(15),                            0, 1, 5,  15, 1});
    tbl.push_back('{mk(1,0, 5,1, 5,1, 13, 9,1,0,0,0,0), 0, 0, 9,  13, 1});
    tbl.push_back('{lw5(16),                            0, 1, 5,  16, 1});
    tbl.push_back('{mk(1,1, 5,1, 2,1, 17, 6,1,0,0,1,0), 0, 0, 0,   0, 1});
    tbl.push_back('{lw5(18),                            0, 1, 5,  18, 1});
    tbl.push_back('{mk(1,1, 1,1, 5,1, 19, 0,0,0,1,0,0), 1, 0, 0,   0, 2});

    foreach (tbl[i]) begin
      cycle(tbl[i].in, st);
      check($sformatf("vec%0d.stall", i), {159'b0, st}, {159'b0, tbl[i].e_stall});
      chk_ex($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_rd, tbl[i].e_op1, tbl[i].e_cnt);
    end

    // Hold freezes EXE while ID keeps changing; release captures current ID.
    cycle(mk(1,1, 1,1, 2,1, 5, 3,1,0,0,0,0), st);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1,1, 5'(i),1, 2,1, 20 + i, 5'(10 + i),1,i[0],0,0,1), st);
      check($sformatf("hold%0d.stall", i), {159'b0, st}, 160'd1);
      chk_ex($sformatf("hold%0d", i), 1, 5'd3, 32'd5, 2);
    end
    cycle(mk(1,1, 1,1, 2,1, 40, 12,1,0,0,0,0), st);
    check("release.stall", {159'b0, st}, 160'd0);
    chk_ex("release", 1, 5'd12, 32'd40, 2);

    // Drive the 4-bit counter from 2 up to 15, then one more bubble wraps it to 0.
    for (int i = 0; i < 13; i++) begin
      cycle(lw5(50 + i), st);
      cycle(mk(1,1, 5,1, 2,0, 60, 6,1,0,0,0,0), st);
    end
    check("cnt_at_15", {156'b0, bubble_cnt_o}, 160'd15);
    cycle(lw5(70), st);
    cycle(mk(1,1, 2,0, 5,1, 71, 6,1,0,0,0,0), st);
    check("cnt_wrap.stall", {159'b0, st}, 160'd1);
    check("cnt_wrap", {156'b0, bubble_cnt_o}, 160'd0);

    mcheck = 1;
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(49, 0) != 0, $urandom_range(3, 0) != 0,
             5'($urandom_range(7, 0)), 1'($urandom), 5'($urandom_range(7, 0)), 1'($urandom),
             $urandom, 5'($urandom_range(7, 0)), 1'($urandom), $urandom_range(2, 0) == 0,
             1'($urandom), $urandom_range(7, 0) == 0, $urandom_range(5, 0) == 0);
      v.op2 = $urandom; v.imm = $urandom; v.pc = $urandom;
      v.aluop = 5'($urandom);
      cycle(v, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
